eeg_stream_capture: RTL and testbench

- Synthesizable multi-channel oscillator sample capture engine.
- Decimates the 4 kHz update strobe by a runtime power of two, in either pick or boxcar-average mode.
- Frames each sample set with a header, tag and sample index, and buffers whole frames in a FIFO.
- Streams 32-bit words over valid/ready, e.g. to a host DMA/UART bridge. It sits beside phi_n_neural_processor and taps its theta, SR and cortical-layer outputs for offline EEG-style spectral analysis.

---
 rtl/eeg_stream_capture_pkg.sv | 21 ++
 rtl/eeg_stream_capture_if.sv | 12 +
 rtl/eeg_frame_fifo.sv | 62 ++++++
 rtl/eeg_stream_capture.sv | 181 ++++++++++++++++++
 tb/tb_eeg_stream_capture.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eeg_stream_capture_pkg.sv
// Shared constants, state encoding and frame geometry for the EEG stream capture engine.
package eeg_stream_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned HDR_WORDS = 2;

  localparam int unsigned W_HEADER = 0;
  localparam int unsigned W_INDEX  = 1;
  localparam int unsigned W_CH0    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } cap_state_e;

  function automatic int unsigned frame_words(input int unsigned num_ch);
    return num_ch + HDR_WORDS;
  endfunction

endpackage

// File: rtl/eeg_stream_capture_if.sv
// 32-bit valid/ready word stream with an end-of-frame marker.
interface eeg_stream_capture_if;

  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/eeg_frame_fifo.sv
// Synchronous word FIFO carrying 32-bit data plus a last flag; reports free space in words.
module eeg_frame_fifo #(
  parameter int unsigned WORDS = 46
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [31:0]                  wr_data,
  input  logic                         wr_last,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [31:0]                  rd_data,
  output logic                         rd_last,
  output logic [$clog2(WORDS+1)-1:0]   free_words
);

  localparam int unsigned CW = $clog2(WORDS + 1);
  localparam int unsigned PW = $clog2(WORDS);

  logic [32:0]   mem [WORDS];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(WORDS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_ready   = (count != CW'(WORDS));
  assign rd_valid   = (count != '0);
  assign do_wr      = wr_valid && wr_ready;
  assign do_rd      = rd_valid && rd_ready;
  assign free_words = CW'(WORDS) - count;

  // Gate the head word so the stream reads all-zero whenever nothing is buffered.
  assign rd_data = rd_valid ? mem[rd_ptr][31:0] : '0;
  assign rd_last = rd_valid && mem[rd_ptr][32];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {wr_last, wr_data};
  end

endmodule

// File: rtl/eeg_stream_capture.sv
// Multi-channel sample capture: tick decimation (pick/boxcar), framing and buffered word streaming.
module eeg_stream_capture
  import eeg_stream_pkg::*;
#(
  parameter int unsigned WIDTH       = 18,
  parameter int unsigned NUM_CH      = 21,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MAX_SAMPLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    enable,
  input  logic [2:0]              decim_log2,
  input  logic                    avg_mode,
  input  logic [15:0]             tag,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  eeg_stream_capture_if.master    strm,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned FW         = frame_words(NUM_CH);
  localparam int unsigned FIFO_WORDS = DEPTH * FW;
  localparam int unsigned CW         = $clog2(FIFO_WORDS + 1);
  localparam int unsigned IW         = $clog2(FW);
  localparam int unsigned ACC_W      = WIDTH + 8;

  cap_state_e state;

  logic                    clk_en_q;
  logic                    enable_q;
  logic                    tick;
  logic                    en_rise;
  logic                    qual;
  logic                    room;
  logic [2:0]              k_lat;
  logic                    avg_lat;
  logic [6:0]              tick_cnt;
  logic [6:0]              tick_mask;
  logic [31:0]             sample_index;
  logic [7:0]              drop_count;
  logic signed [ACC_W-1:0] acc     [NUM_CH];
  logic signed [ACC_W-1:0] acc_sum [NUM_CH];
  logic signed [WIDTH-1:0] ch_val  [NUM_CH];
  logic signed [WIDTH-1:0] cap     [NUM_CH];
  logic [15:0]             tag_cap;
  logic [31:0]             index_cap;
  logic                    wr_active;
  logic [IW-1:0]           wr_idx;
  logic [31:0]             wr_word;
  logic                    wr_last;
  logic                    wr_ready;
  logic [CW-1:0]           free_words;

  assign tick      = clk_en && !clk_en_q;
  assign en_rise   = enable && !enable_q;
  assign tick_mask = ~(7'h7F << k_lat);
  assign qual      = (state == ST_RUN) && enable && tick && (tick_cnt == tick_mask);
  // A frame still being written has not yet consumed its FIFO space, so treat it as no room.
  assign room      = !wr_active && (32'(free_words) >= FW);

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      acc_sum[i] = acc[i] + ACC_W'($signed(ch_data[i*WIDTH +: WIDTH]));
      ch_val[i]  = avg_lat ? WIDTH'(acc_sum[i] >>> k_lat)
                           : $signed(ch_data[i*WIDTH +: WIDTH]);
    end
  end

  always_comb begin
    wr_word = '0;
    if (32'(wr_idx) == W_HEADER) wr_word = {SYNC_BYTE, drop_count, tag_cap};
    else if (32'(wr_idx) == W_INDEX) wr_word = index_cap;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(wr_idx) == i + W_CH0) wr_word = 32'(cap[i]);
    end
    wr_last = (32'(wr_idx) == FW - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      clk_en_q     <= 1'b0;
      enable_q     <= 1'b0;
      k_lat        <= '0;
      avg_lat      <= 1'b0;
      tick_cnt     <= '0;
      sample_index <= '0;
      drop_count   <= '0;
      tag_cap      <= '0;
      index_cap    <= '0;
      wr_active    <= 1'b0;
      wr_idx       <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cap[i] <= '0;
      end
    end else begin
      clk_en_q <= clk_en;
      enable_q <= enable;

      // Frame writer runs independently of the run state so a started frame always completes.
      if (wr_active && wr_ready) begin
        if (32'(wr_idx) == FW - 1) begin
          wr_active <= 1'b0;
          wr_idx    <= '0;
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          if (en_rise) begin
            state        <= ST_RUN;
            busy         <= 1'b1;
            k_lat        <= decim_log2;
            avg_lat      <= avg_mode;
            tick_cnt     <= '0;
            sample_index <= '0;
            drop_count   <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= '0;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            tick_cnt <= (tick_cnt + 7'd1) & tick_mask;
            for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= qual ? '0 : acc_sum[i];
            if (qual) begin
              sample_index <= sample_index + 32'd1;
              if (room) begin
                cap       <= ch_val;
                tag_cap   <= tag;
                index_cap <= sample_index;
                wr_active <= 1'b1;
                wr_idx    <= '0;
              end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
              end
              if (MAX_SAMPLES != 0 && sample_index == 32'(MAX_SAMPLES - 1)) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (!enable) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  eeg_frame_fifo #(
    .WORDS(FIFO_WORDS)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_active),
    .wr_ready   (wr_ready),
    .wr_data    (wr_word),
    .wr_last    (wr_last),
    .rd_valid   (strm.m_valid),
    .rd_ready   (strm.m_ready),
    .rd_data    (strm.m_data),
    .rd_last    (strm.m_last),
    .free_words (free_words)
  );

endmodule

// File: tb/tb_eeg_stream_capture.sv
// Directed scoreboard bench for eeg_stream_capture with a small 3-channel, 2-frame configuration.
module tb_eeg_stream_capture;

  localparam int unsigned WIDTH       = 18;
  localparam int unsigned NUM_CH      = 3;
  localparam int unsigned DEPTH       = 2;
  localparam int unsigned MAX_SAMPLES = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clk_en;
  logic                    enable;
  logic [2:0]              decim_log2;
  logic                    avg_mode;
  logic [15:0]             tag;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic                    busy;
  logic                    done;

  eeg_stream_capture_if strm ();

  eeg_stream_capture #(
    .WIDTH       (WIDTH),
    .NUM_CH      (NUM_CH),
    .DEPTH       (DEPTH),
    .MAX_SAMPLES (MAX_SAMPLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .enable     (enable),
    .decim_log2 (decim_log2),
    .avg_mode   (avg_mode),
    .tag        (tag),
    .ch_data    (ch_data),
    .strm       (strm),
    .busy       (busy),
    .done       (done)
  );

  always #4 clk = ~clk;

  logic [32:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Scoreboard: every accepted stream word must match the head of the expected queue.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && strm.m_valid && strm.m_ready) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_word observed=%0h expected=none", {strm.m_last, strm.m_data});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stream_word", {31'd0, strm.m_last, strm.m_data}, {31'd0, e});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int a, input int b, input int c);
    ch_data = {WIDTH'(c), WIDTH'(b), WIDTH'(a)};
  endtask

  task automatic do_tick(input int width);
    clk_en = 1'b1;
    cyc(width);
    clk_en = 1'b0;
    cyc(12);
  endtask

  task automatic push_frame(input int idx, input int drop, input logic [15:0] tg,
                            input int a, input int b, input int c);
    exp_q.push_back({1'b0, 8'hA5, 8'(drop), tg});
    exp_q.push_back({1'b0, 32'(idx)});
    exp_q.push_back({1'b0, 32'(a)});
    exp_q.push_back({1'b0, 32'(b)});
    exp_q.push_back({1'b1, 32'(c)});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || strm.m_valid) && n < 400) begin
      cyc(1);
      n++;
    end
    chk(name, 64'(n < 400), 64'd1);
  endtask

  function automatic int floor_div(input int s, input int d);
    int q = s / d;
    if ((s % d != 0) && ((s < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  initial begin
    logic [31:0] hold_data;
    logic        hold_last;
    int          n;
    int          v[4];

    rst = 1'b1; clk_en = 1'b0; enable = 1'b0; decim_log2 = 3'd0; avg_mode = 1'b0;
    tag = 16'h0; ch_data = '0; strm.m_ready = 1'b1;
    cyc(3);
    chk("rst_valid", 64'(strm.m_valid), 64'd0);
    chk("rst_data",  64'(strm.m_data),  64'd0);
    chk("rst_last",  64'(strm.m_last),  64'd0);
    chk("rst_busy",  64'(busy),         64'd0);
    chk("rst_done",  64'(done),         64'd0);
    rst = 1'b0;
    cyc(2);

    // Pick mode, k=2: frames on ticks 4, 8, 12
    decim_log2 = 3'd2; avg_mode = 1'b0; enable = 1'b1;
    cyc(3);
    chk("pick_busy", 64'(busy), 64'd1);
    for (int t = 0; t < 12; t++) begin
      set_ch(t, -t, 131071);
      tag = 16'h0100 + 16'(t);
      if (t % 4 == 3) push_frame(t / 4, 0, tag, t, -t, 131071);
      if (t == 3) begin
        clk_en = 1'b1;
        cyc(1);
        chk("latency_t1", 64'(strm.m_valid), 64'd0);
        cyc(1);
        chk("latency_t2", 64'(strm.m_valid), 64'd1);
        clk_en = 1'b0;
        cyc(12);
      end else begin
        do_tick(1);
      end
    end
    wait_drain("pick_drain");
    enable = 1'b0;
    cyc(3);
    chk("pick_idle_busy", 64'(busy), 64'd0);

    // Boxcar average, k=2
    decim_log2 = 3'd2; avg_mode = 1'b1; enable = 1'b1;
    cyc(3);
    v = '{1, 2, 3, -7};
    tag = 16'hBEEF;
    for (int t = 0; t < 4; t++) begin
      set_ch(v[t], -5, 7);
      if (t == 3) push_frame(0, 0, tag, floor_div(1 + 2 + 3 - 7, 4), -5, 7);
      do_tick(1);
    end
    tag = 16'hCAFE;
    for (int t = 0; t < 4; t++) begin
      set_ch(100, -5, 7);
      if (t == 3) push_frame(1, 0, tag, 100, -5, 7);
      do_tick(1);
    end
    wait_drain("avg_drain");
    enable = 1'b0;
    cyc(3);

    // Backpressure: two frames fit, third is dropped
    decim_log2 = 3'd0; avg_mode = 1'b0; strm.m_ready = 1'b0; enable = 1'b1;
    cyc(3);
    for (int t = 0; t < 3; t++) begin
      set_ch(10 + t, 20 + t, -30 - t);
      tag = 16'h2000 + 16'(t);
      if (t < 2) push_frame(t, 0, tag, 10 + t, 20 + t, -30 - t);
      do_tick(1);
    end
    chk("bp_valid", 64'(strm.m_valid), 64'd1);
    strm.m_ready = 1'b1;
    wait_drain("bp_drain");
    set_ch(-1, -2, -3);
    tag = 16'h2003;
    push_frame(3, 1, tag, -1, -2, -3);
    do_tick(1);
    wait_drain("bp_after_drain");
    chk("bp_busy", 64'(busy), 64'd1);
    enable = 1'b0;
    cyc(3);

    // MAX_SAMPLES stop
    enable = 1'b1;
    cyc(3);
    for (int t = 0; t < 5; t++) begin
      set_ch(t * 3, 1, 2);
      tag = 16'h3000 + 16'(t);
      push_frame(t, 0, tag, t * 3, 1, 2);
      do_tick(1);
    end
    chk("max_done", 64'(done), 64'd1);
    chk("max_busy", 64'(busy), 64'd0);
    do_tick(1);
    do_tick(1);
    wait_drain("max_drain");
    chk("max_done_hold", 64'(done), 64'd1);
    enable = 1'b0;
    cyc(1);
    chk("max_done_clear", 64'(done), 64'd0);
    enable = 1'b1;
    cyc(3);
    set_ch(55, 66, 77);
    tag = 16'h3100;
    push_frame(0, 0, tag, 55, 66, 77);
    do_tick(1);
    wait_drain("max_restart_drain");
    enable = 1'b0;
    cyc(3);

    // Wide strobes, then reset mid-frame
    enable = 1'b1;
    cyc(3);
    for (int t = 0; t < 3; t++) begin
      set_ch(-t, t, 9);
      tag = 16'h4000 + 16'(t);
      push_frame(t, 0, tag, -t, t, 9);
      do_tick(3);
    end
    wait_drain("strobe_drain");
    strm.m_ready = 1'b0;
    set_ch(1, 1, 1);
    do_tick(1);
    chk("rst_mid_valid_pre", 64'(strm.m_valid), 64'd1);
    rst = 1'b1; enable = 1'b0;
    cyc(1);
    chk("rst_mid_valid", 64'(strm.m_valid), 64'd0);
    chk("rst_mid_busy",  64'(busy),         64'd0);
    exp_q.delete();
    rst = 1'b0; strm.m_ready = 1'b1;
    cyc(2);
    enable = 1'b1;
    cyc(3);
    set_ch(-100, 200, -300);
    tag = 16'h5000;
    push_frame(0, 0, tag, -100, 200, -300);
    do_tick(1);
    wait_drain("rst_restart_drain");

    // Stall stability on the head word
    strm.m_ready = 1'b0;
    set_ch(4, 5, 6);
    tag = 16'h6000;
    push_frame(1, 0, tag, 4, 5, 6);
    clk_en = 1'b1;
    cyc(1);
    clk_en = 1'b0;
    n = 0;
    while (!strm.m_valid && n < 20) begin
      cyc(1);
      n++;
    end
    chk("stall_valid", 64'(strm.m_valid), 64'd1);
    hold_data = strm.m_data;
    hold_last = strm.m_last;
    for (int t = 0; t < 10; t++) begin
      cyc(1);
      chk("stall_data", 64'(strm.m_data), 64'(hold_data));
      chk("stall_last", 64'(strm.m_last), 64'(hold_last));
    end
    strm.m_ready = 1'b1;
    wait_drain("stall_drain");
    enable = 1'b0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
